decode_stage: RTL and testbench

//   MIPS five-stage pipeline decode (D) stage.
//   - Holds the 32x32 register file; applies D-stage forwarding to the rs/rt read data.
//   - Resolves branches and jumps in D (one delay slot) and produces the redirect PC.
//   - Extends the 16-bit immediate and registers everything into the D/E pipeline register.

---
 rtl/decode_stage.sv | 228 ++++++++++++++++++++++
 tb/tb_decode_stage.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// decode_stage: MIPS five-stage pipeline decode (D) stage.
// Holds the 32x32 register file, forwards W/M/E results into the rs/rt read
// data, resolves branches and jumps in D (one delay slot), extends the
// immediate and registers everything into the D/E pipeline register.
// Optional feature: define DECODE_RF_BYPASS_EN to let a same-cycle W-stage
// write show up on the register-file read ports (otherwise reads return the
// stored value and W data reaches D only through forward select 4).
module decode_stage (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] IRD,
  input  logic [31:0] PC8D,
  input  logic        FlushE,
  input  logic [2:0]  Forward_RS_D_Sel,
  input  logic [2:0]  Forward_RT_D_Sel,
  input  logic [31:0] PC8fromE,
  input  logic [31:0] AO,
  input  logic [31:0] PC8fromM,
  input  logic [31:0] MUX_RF_WD_OUT,
  input  logic [4:0]  MUX_RF_A3_OUT,
  input  logic        We,
  output logic        Branch,
  output logic [1:0]  NPC_Sel,
  output logic [31:0] NPC,
  output logic [31:0] IRE,
  output logic [31:0] PC8E,
  output logic [31:0] RSE,
  output logic [31:0] RTE,
  output logic [31:0] EXTE
);

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_REGIMM  = 6'b000001;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] OP_BLEZ    = 6'b000110;
  localparam logic [5:0] OP_BGTZ    = 6'b000111;
  localparam logic [5:0] OP_ANDI    = 6'b001100;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_XORI    = 6'b001110;
  localparam logic [5:0] OP_LUI     = 6'b001111;
  localparam logic [5:0] FN_JR      = 6'b001000;
  localparam logic [5:0] FN_JALR    = 6'b001001;

  // Forward mux shared by rs and rt; unused selects fall back to the RF read.
  function automatic logic [31:0] fwd_mux(
    input logic [2:0]  sel,
    input logic [31:0] rf_val,
    input logic [31:0] e_val,
    input logic [31:0] m_alu,
    input logic [31:0] m_pc8,
    input logic [31:0] w_val
  );
    logic [31:0] res;
    case (sel)
      3'd1:    res = e_val;
      3'd2:    res = m_alu;
      3'd3:    res = m_pc8;
      3'd4:    res = w_val;
      default: res = rf_val;
    endcase
    return res;
  endfunction

  logic [31:0] rf_q [32];
  logic [31:0] rf_d [32];

  logic [5:0]  op_s;
  logic [5:0]  funct_s;
  logic [4:0]  rs_addr_s;
  logic [4:0]  rt_addr_s;
  logic [15:0] imm_s;
  logic        byp_rs_s;
  logic        byp_rt_s;
  logic [31:0] rf_rs_s;
  logic [31:0] rf_rt_s;
  logic [31:0] fwd_rs_s;
  logic [31:0] fwd_rt_s;
  logic        branch_s;
  logic [1:0]  npc_sel_s;
  logic [31:0] npc_s;
  logic [31:0] br_off_s;
  logic [31:0] ext_s;

  logic [31:0] ire_d,  ire_q;
  logic [31:0] pc8e_d, pc8e_q;
  logic [31:0] rse_d,  rse_q;
  logic [31:0] rte_d,  rte_q;
  logic [31:0] exte_d, exte_q;

  assign op_s      = IRD[31:26];
  assign funct_s   = IRD[5:0];
  assign rs_addr_s = IRD[25:21];
  assign rt_addr_s = IRD[20:16];
  assign imm_s     = IRD[15:0];

`ifdef DECODE_RF_BYPASS_EN
  assign byp_rs_s = We && (MUX_RF_A3_OUT != 5'd0) && (MUX_RF_A3_OUT == rs_addr_s);
  assign byp_rt_s = We && (MUX_RF_A3_OUT != 5'd0) && (MUX_RF_A3_OUT == rt_addr_s);
`else
  assign byp_rs_s = 1'b0;
  assign byp_rt_s = 1'b0;
`endif

  // Register-file next state: W-stage write, $0 never written.
  always_comb begin
    for (int i = 0; i < 32; i++) begin
      rf_d[i] = (We && (MUX_RF_A3_OUT == 5'(i)) && (i != 0)) ? MUX_RF_WD_OUT : rf_q[i];
    end
  end

  // Register-file storage, cleared by reset.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
    end else begin
      for (int i = 0; i < 32; i++) rf_q[i] <= rf_d[i];
    end
  end

  // Register reads followed by the D-stage forward muxes.
  always_comb begin
    rf_rs_s  = byp_rs_s ? MUX_RF_WD_OUT : ((rs_addr_s == 5'd0) ? 32'd0 : rf_q[rs_addr_s]);
    rf_rt_s  = byp_rt_s ? MUX_RF_WD_OUT : ((rt_addr_s == 5'd0) ? 32'd0 : rf_q[rt_addr_s]);
    fwd_rs_s = fwd_mux(Forward_RS_D_Sel, rf_rs_s, PC8fromE, AO, PC8fromM, MUX_RF_WD_OUT);
    fwd_rt_s = fwd_mux(Forward_RT_D_Sel, rf_rt_s, PC8fromE, AO, PC8fromM, MUX_RF_WD_OUT);
  end

  // Branch condition evaluation on the forwarded operands.
  always_comb begin
    branch_s = 1'b0;
    case (op_s)
      OP_BEQ:  branch_s = (fwd_rs_s == fwd_rt_s);
      OP_BNE:  branch_s = (fwd_rs_s != fwd_rt_s);
      OP_BLEZ: branch_s = ($signed(fwd_rs_s) <= 32'sd0);
      OP_BGTZ: branch_s = ($signed(fwd_rs_s) > 32'sd0);
      OP_REGIMM: begin
        case (rt_addr_s)
          5'd0:    branch_s = fwd_rs_s[31];
          5'd1:    branch_s = !fwd_rs_s[31];
          default: branch_s = 1'b0;
        endcase
      end
      default: branch_s = 1'b0;
    endcase
  end

  // Next-PC selection: taken branch, j/jal, jr/jalr, else fall through.
  always_comb begin
    npc_sel_s = 2'b00;
    npc_s     = PC8D;
    br_off_s  = {{14{imm_s[15]}}, imm_s, 2'b00};
    if (branch_s) begin
      npc_sel_s = 2'b01;
      npc_s     = (PC8D - 32'd4) + br_off_s;
    end else if ((op_s == OP_J) || (op_s == OP_JAL)) begin
      npc_sel_s = 2'b10;
      npc_s     = {PC8D[31:28], IRD[25:0], 2'b00};
    end else if ((op_s == OP_SPECIAL) && ((funct_s == FN_JR) || (funct_s == FN_JALR))) begin
      npc_sel_s = 2'b11;
      npc_s     = fwd_rs_s;
    end else begin
      npc_sel_s = 2'b00;
      npc_s     = PC8D;
    end
  end

  // Immediate extender: logical ops zero-extend, lui shifts up, rest sign-extend.
  always_comb begin
    ext_s = {{16{imm_s[15]}}, imm_s};
    case (op_s)
      OP_ANDI, OP_ORI, OP_XORI: ext_s = {16'd0, imm_s};
      OP_LUI:                   ext_s = {imm_s, 16'd0};
      default:                  ext_s = {{16{imm_s[15]}}, imm_s};
    endcase
  end

  // D/E register next state: a flush loads an all-zero nop bubble.
  always_comb begin
    ire_d  = IRD;
    pc8e_d = PC8D;
    rse_d  = fwd_rs_s;
    rte_d  = fwd_rt_s;
    exte_d = ext_s;
    if (FlushE) begin
      ire_d  = 32'd0;
      pc8e_d = 32'd0;
      rse_d  = 32'd0;
      rte_d  = 32'd0;
      exte_d = 32'd0;
    end else begin
      ire_d  = IRD;
      pc8e_d = PC8D;
      rse_d  = fwd_rs_s;
      rte_d  = fwd_rt_s;
      exte_d = ext_s;
    end
  end

  // D/E pipeline register.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      ire_q  <= 32'd0;
      pc8e_q <= 32'd0;
      rse_q  <= 32'd0;
      rte_q  <= 32'd0;
      exte_q <= 32'd0;
    end else begin
      ire_q  <= ire_d;
      pc8e_q <= pc8e_d;
      rse_q  <= rse_d;
      rte_q  <= rte_d;
      exte_q <= exte_d;
    end
  end

  assign Branch  = branch_s;
  assign NPC_Sel = npc_sel_s;
  assign NPC     = npc_s;
  assign IRE     = ire_q;
  assign PC8E    = pc8e_q;
  assign RSE     = rse_q;
  assign RTE     = rte_q;
  assign EXTE    = exte_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed and randomized checks of decode_stage against a
// behavioural model (register array plus MIPS decode rules in plain arithmetic).
module tb_decode_stage;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [31:0] IRD;
  logic [31:0] PC8D;
  logic        FlushE;
  logic [2:0]  Forward_RS_D_Sel;
  logic [2:0]  Forward_RT_D_Sel;
  logic [31:0] PC8fromE;
  logic [31:0] AO;
  logic [31:0] PC8fromM;
  logic [31:0] MUX_RF_WD_OUT;
  logic [4:0]  MUX_RF_A3_OUT;
  logic        We;
  logic        Branch;
  logic [1:0]  NPC_Sel;
  logic [31:0] NPC;
  logic [31:0] IRE, PC8E, RSE, RTE, EXTE;

  always #5 Clk = ~Clk;

  decode_stage dut (
    .Clk(Clk), .Reset(Reset), .IRD(IRD), .PC8D(PC8D), .FlushE(FlushE),
    .Forward_RS_D_Sel(Forward_RS_D_Sel), .Forward_RT_D_Sel(Forward_RT_D_Sel),
    .PC8fromE(PC8fromE), .AO(AO), .PC8fromM(PC8fromM),
    .MUX_RF_WD_OUT(MUX_RF_WD_OUT), .MUX_RF_A3_OUT(MUX_RF_A3_OUT), .We(We),
    .Branch(Branch), .NPC_Sel(NPC_Sel), .NPC(NPC),
    .IRE(IRE), .PC8E(PC8E), .RSE(RSE), .RTE(RTE), .EXTE(EXTE)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] m_rf [32];
  logic        s_br;
  logic [1:0]  s_sel;
  logic [31:0] s_npc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
`ifdef DECODE_RF_BYPASS_EN
    if (We && (MUX_RF_A3_OUT == a)) return MUX_RF_WD_OUT;
`endif
    return m_rf[a];
  endfunction

  function automatic logic [31:0] m_fwd(input logic [2:0] sel, input logic [4:0] a);
    case (sel)
      3'd1:    return PC8fromE;
      3'd2:    return AO;
      3'd3:    return PC8fromM;
      3'd4:    return MUX_RF_WD_OUT;
      default: return m_read(a);
    endcase
  endfunction

  // One D-stage cycle: check combinational redirect, clock, check D/E, update model.
  task automatic step(input string tag);
    int          op;
    int          fn;
    int          rtf;
    int          imm_i;
    int          rs_i;
    logic [31:0] rs_v, rt_v, ext_v;
    logic        exp_br;
    logic [1:0]  exp_sel;
    logic [31:0] exp_npc;
    op    = int'(IRD[31:26]);
    fn    = int'(IRD[5:0]);
    rtf   = int'(IRD[20:16]);
    imm_i = int'($signed(IRD[15:0]));
    rs_v  = m_fwd(Forward_RS_D_Sel, IRD[25:21]);
    rt_v  = m_fwd(Forward_RT_D_Sel, IRD[20:16]);
    rs_i  = int'($signed(rs_v));
    case (op)
      4:       exp_br = (rs_v == rt_v);
      5:       exp_br = (rs_v != rt_v);
      6:       exp_br = (rs_i <= 0);
      7:       exp_br = (rs_i > 0);
      1:       exp_br = (rtf == 0) ? (rs_i < 0) : ((rtf == 1) ? (rs_i >= 0) : 1'b0);
      default: exp_br = 1'b0;
    endcase
    if (exp_br) begin
      exp_sel = 2'b01;
      exp_npc = PC8D + 32'(imm_i * 4 - 4);
    end else if (op == 2 || op == 3) begin
      exp_sel = 2'b10;
      exp_npc = (PC8D & 32'hF000_0000) | (32'(IRD[25:0]) << 2);
    end else if (op == 0 && (fn == 8 || fn == 9)) begin
      exp_sel = 2'b11;
      exp_npc = rs_v;
    end else begin
      exp_sel = 2'b00;
      exp_npc = PC8D;
    end
    if (op >= 12 && op <= 14)  ext_v = 32'(IRD[15:0]);
    else if (op == 15)         ext_v = 32'(IRD[15:0]) << 16;
    else                       ext_v = 32'(imm_i);
    #1;
    s_br  = Branch;
    s_sel = NPC_Sel;
    s_npc = NPC;
    check({tag, ".branch"}, {31'd0, Branch}, {31'd0, exp_br});
    check({tag, ".npc_sel"}, {30'd0, NPC_Sel}, {30'd0, exp_sel});
    check({tag, ".npc"}, NPC, exp_npc);
    @(posedge Clk);
    #1;
    if (FlushE) begin
      check({tag, ".ire"},  IRE,  32'd0);
      check({tag, ".pc8e"}, PC8E, 32'd0);
      check({tag, ".rse"},  RSE,  32'd0);
      check({tag, ".rte"},  RTE,  32'd0);
      check({tag, ".exte"}, EXTE, 32'd0);
    end else begin
      check({tag, ".ire"},  IRE,  IRD);
      check({tag, ".pc8e"}, PC8E, PC8D);
      check({tag, ".rse"},  RSE,  rs_v);
      check({tag, ".rte"},  RTE,  rt_v);
      check({tag, ".exte"}, EXTE, ext_v);
    end
    if (We && MUX_RF_A3_OUT != 5'd0) m_rf[MUX_RF_A3_OUT] = MUX_RF_WD_OUT;
  endtask

  task automatic idle();
    IRD = 32'd0; PC8D = 32'd0; FlushE = 1'b0;
    Forward_RS_D_Sel = 3'd0; Forward_RT_D_Sel = 3'd0;
    PC8fromE = 32'd0; AO = 32'd0; PC8fromM = 32'd0;
    MUX_RF_WD_OUT = 32'd0; MUX_RF_A3_OUT = 5'd0; We = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] v);
    idle();
    We = 1'b1; MUX_RF_A3_OUT = a; MUX_RF_WD_OUT = v;
    step("wr");
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'd7;
      default: return $urandom;
    endcase
  endfunction

  task automatic rand_step();
    logic [5:0] ops [14];
    logic [5:0] fns [4];
    logic [5:0] op;
    ops = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06,
            6'h07, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h08, 6'h23};
    fns = '{6'h08, 6'h09, 6'h20, 6'h21};
    op  = ops[$urandom_range(0, 13)];
    IRD = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 3)), 16'($urandom)};
    if (op == 6'h00) IRD[5:0] = fns[$urandom_range(0, 3)];
    if (op == 6'h02 || op == 6'h03) IRD[25:0] = 26'($urandom);
    PC8D             = $urandom;
    FlushE           = ($urandom_range(0, 9) == 0);
    Forward_RS_D_Sel = 3'($urandom_range(0, 7));
    Forward_RT_D_Sel = 3'($urandom_range(0, 7));
    PC8fromE         = pick_val();
    AO               = pick_val();
    PC8fromM         = pick_val();
    MUX_RF_WD_OUT    = pick_val();
    MUX_RF_A3_OUT    = 5'($urandom_range(0, 7));
    We               = 1'($urandom_range(0, 1));
    step("rnd");
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    Reset = 1'b0;
    idle();
    #12;
    check("reset.ire",  IRE,  32'd0);
    check("reset.pc8e", PC8E, 32'd0);
    check("reset.rse",  RSE,  32'd0);
    check("reset.rte",  RTE,  32'd0);
    check("reset.exte", EXTE, 32'd0);
    Reset = 1'b1;
    @(posedge Clk);
    #1;

    // ori $9,$8,0xFFFF after writing $8=5
    wr(5'd8, 32'd5);
    idle(); IRD = {6'h0D, 5'd8, 5'd9, 16'hFFFF};
    step("ori");
    check("t1.rse", RSE, 32'd5);
    check("t1.exte", EXTE, 32'h0000_FFFF);

    // beq / bne with equal operands
    wr(5'd1, 32'd7);
    wr(5'd2, 32'd7);
    idle(); IRD = {6'h04, 5'd1, 5'd2, 16'd3}; PC8D = 32'h3008;
    step("beq");
    check("t2.beq_br", {31'd0, s_br}, 32'd1);
    check("t2.beq_sel", {30'd0, s_sel}, 32'd1);
    check("t2.beq_npc", s_npc, 32'h3010);
    IRD = {6'h05, 5'd1, 5'd2, 16'd3};
    step("bne");
    check("t2.bne_br", {31'd0, s_br}, 32'd0);
    check("t2.bne_sel", {30'd0, s_sel}, 32'd0);
    check("t2.bne_npc", s_npc, 32'h3008);

    // jal and jr
    idle(); IRD = {6'h03, 26'h0100000}; PC8D = 32'h3008;
    step("jal");
    check("t3.jal_sel", {30'd0, s_sel}, 32'd2);
    check("t3.jal_npc", s_npc, 32'h0040_0000);
    idle(); IRD = {6'h00, 5'd31, 15'd0, 6'h08}; Forward_RS_D_Sel = 3'd2; AO = 32'h3040;
    step("jr");
    check("t3.jr_sel", {30'd0, s_sel}, 32'd3);
    check("t3.jr_npc", s_npc, 32'h3040);

    // rt forwarding selects
    for (int s = 1; s <= 4; s++) begin
      idle();
      IRD = {6'h00, 5'd0, 5'd2, 5'd3, 5'd0, 6'h20};
      PC8fromE = 32'd1; AO = 32'd2; PC8fromM = 32'd3; MUX_RF_WD_OUT = 32'd4;
      Forward_RT_D_Sel = 3'(s);
      step("fwd");
      check("t4.rte", RTE, 32'(s));
    end
    Forward_RT_D_Sel = 3'd6;
    step("fwd6");
    check("t4.rte_sel6", RTE, 32'd7);

    // flush bubble, then lui, then $0 stays zero
    idle(); IRD = {6'h0F, 5'd0, 5'd3, 16'h8000}; PC8D = 32'h1234; FlushE = 1'b1;
    step("flush");
    check("t5.flush_ire", IRE, 32'd0);
    check("t5.flush_exte", EXTE, 32'd0);
    FlushE = 1'b0;
    step("lui");
    check("t5.lui_exte", EXTE, 32'h8000_0000);
    wr(5'd0, 32'd9);
    idle(); IRD = {6'h00, 5'd0, 5'd0, 16'h0020};
    step("r0");
    check("t5.r0_rse", RSE, 32'd0);
    check("t5.r0_rte", RTE, 32'd0);

    // same-cycle write and read of the same register
    wr(5'd5, 32'd11);
    idle(); IRD = {6'h00, 5'd5, 5'd0, 16'h0020};
    We = 1'b1; MUX_RF_A3_OUT = 5'd5; MUX_RF_WD_OUT = 32'd22;
    step("rw_same");

    for (int n = 0; n < 300; n++) rand_step();

    // asynchronous reset in the middle of operation
    Reset = 1'b0;
    #2;
    check("midrst.ire",  IRE,  32'd0);
    check("midrst.rse",  RSE,  32'd0);
    check("midrst.exte", EXTE, 32'd0);
    for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    idle(); IRD = {6'h04, 5'd1, 5'd2, 16'd3}; PC8D = 32'h3008;
    #1;
    check("midrst.branch", {31'd0, Branch}, 32'd1);
    check("midrst.npc", NPC, 32'h3010);
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    for (int n = 0; n < 150; n++) rand_step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
